// File: rtl/inst_encoder.sv
// MIPS32 instruction encoder: turns an operation_t plus operand fields into a 32-bit word.
// Encoded words queue in a small FIFO; ops the decoder cannot map are dropped and reported.
package inst_encoder_pkg;
  typedef enum logic [6:0] {
    OP_INVALID,
    OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV, OP_JR, OP_JALR, OP_MOVZ, OP_MOVN,
    OP_SYSCALL, OP_BREAK, OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
    OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_BLTZ, OP_BGEZ, OP_BLTZAL, OP_BGEZAL, OP_BLTZL, OP_BGEZL, OP_BLTZALL, OP_BGEZALL,
    OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BEQL, OP_BNEL, OP_BLEZL, OP_BGTZL,
    OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
    OP_MFC0, OP_MTC0, OP_TLBR, OP_TLBWI, OP_TLBWR, OP_TLBP, OP_ERET,
    OP_MADD, OP_MADDU, OP_MUL, OP_MSUB, OP_MSUBU, OP_CLZ, OP_CLO,
    OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
    OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR, OP_CACHE
  } operation_t;
endpackage

module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  operation_t       req_op,
  input  logic [4:0]       req_rs,
  input  logic [4:0]       req_rt,
  input  logic [4:0]       req_rd,
  input  logic [4:0]       req_sa,
  input  logic [15:0]      req_imm,
  input  logic [25:0]      req_jidx,
  input  logic [2:0]       req_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             err,
  output operation_t       err_op,
  output logic [CNT_W-1:0] emit_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  localparam logic [1:0] FMT_R = 2'd0;
  localparam logic [1:0] FMT_I = 2'd1;
  localparam logic [1:0] FMT_J = 2'd2;
  localparam logic [1:0] FMT_C = 2'd3;

  logic [5:0]  opc_s, fn_s;
  logic [3:0]  use_s;           // {rs, rt, rd, sa} taken from the request
  logic [1:0]  fmt_s;
  logic [4:0]  fix_rs_s, fix_rt_s;
  logic        legal_s;
  logic [4:0]  rs_s, rt_s, rd_s, sa_s;
  logic [31:0] word_s;
  logic        push_s, pop_s, illegal_s;

  logic [31:0]      mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [AW:0]      count_r;
  logic             out_valid_r;
  logic             err_r;
  operation_t       err_op_r;
  logic [CNT_W-1:0] emit_cnt_r, illegal_cnt_r;

  // Operation lookup: opcode, function code, used fields and fixed sub-codes
  always_comb begin
    opc_s    = 6'h00;
    fn_s     = 6'h00;
    use_s    = 4'b0000;
    fmt_s    = FMT_R;
    fix_rs_s = 5'd0;
    fix_rt_s = 5'd0;
    legal_s  = 1'b1;
    case (req_op)
      OP_SLL:     begin fn_s = 6'h00; use_s = 4'b0111; end
      OP_SRL:     begin fn_s = 6'h02; use_s = 4'b0111; end
      OP_SRA:     begin fn_s = 6'h03; use_s = 4'b0111; end
      OP_SLLV:    begin fn_s = 6'h04; use_s = 4'b1110; end
      OP_SRLV:    begin fn_s = 6'h06; use_s = 4'b1110; end
      OP_SRAV:    begin fn_s = 6'h07; use_s = 4'b1110; end
      OP_JR:      begin fn_s = 6'h08; use_s = 4'b1000; end
      OP_JALR:    begin fn_s = 6'h09; use_s = 4'b1010; end
      OP_MOVZ:    begin fn_s = 6'h0A; use_s = 4'b1110; end
      OP_MOVN:    begin fn_s = 6'h0B; use_s = 4'b1110; end
      OP_SYSCALL: begin fn_s = 6'h0C; fmt_s = FMT_C; end
      OP_BREAK:   begin fn_s = 6'h0D; fmt_s = FMT_C; end
      OP_MFHI:    begin fn_s = 6'h10; use_s = 4'b0010; end
      OP_MTHI:    begin fn_s = 6'h11; use_s = 4'b1000; end
      OP_MFLO:    begin fn_s = 6'h12; use_s = 4'b0010; end
      OP_MTLO:    begin fn_s = 6'h13; use_s = 4'b1000; end
      OP_MULT:    begin fn_s = 6'h18; use_s = 4'b1100; end
      OP_MULTU:   begin fn_s = 6'h19; use_s = 4'b1100; end
      OP_DIV:     begin fn_s = 6'h1A; use_s = 4'b1100; end
      OP_DIVU:    begin fn_s = 6'h1B; use_s = 4'b1100; end
      OP_ADD:     begin fn_s = 6'h20; use_s = 4'b1110; end
      OP_ADDU:    begin fn_s = 6'h21; use_s = 4'b1110; end
      OP_SUB:     begin fn_s = 6'h22; use_s = 4'b1110; end
      OP_SUBU:    begin fn_s = 6'h23; use_s = 4'b1110; end
      OP_AND:     begin fn_s = 6'h24; use_s = 4'b1110; end
      OP_OR:      begin fn_s = 6'h25; use_s = 4'b1110; end
      OP_XOR:     begin fn_s = 6'h26; use_s = 4'b1110; end
      OP_NOR:     begin fn_s = 6'h27; use_s = 4'b1110; end
      OP_SLT:     begin fn_s = 6'h2A; use_s = 4'b1110; end
      OP_SLTU:    begin fn_s = 6'h2B; use_s = 4'b1110; end
      OP_BLTZ:    begin opc_s = 6'h01; fmt_s = FMT_I; use_s = 4'b1000; fix_rt_s = 5'h00; end
      OP_BGEZ:    begin opc_s = 6'h01; fmt_s = FMT_I; use_s = 4'b1000; fix_rt_s = 5'h01; end
      OP_BLTZAL:  begin opc_s = 6'h01; fmt_s = FMT_I; use_s = 4'b1000; fix_rt_s = 5'h10; end
      OP_BGEZAL:  begin opc_s = 6'h01; fmt_s = FMT_I; use_s = 4'b1000; fix_rt_s = 5'h11; end
      OP_J:       begin opc_s = 6'h02; fmt_s = FMT_J; end
      OP_JAL:     begin opc_s = 6'h03; fmt_s = FMT_J; end
      OP_BEQ:     begin opc_s = 6'h04; fmt_s = FMT_I; use_s = 4'b1100; end
      OP_BNE:     begin opc_s = 6'h05; fmt_s = FMT_I; use_s = 4'b1100; end
      OP_BLEZ:    begin opc_s = 6'h06; fmt_s = FMT_I; use_s = 4'b1000; end
      OP_BGTZ:    begin opc_s = 6'h07; fmt_s = FMT_I; use_s = 4'b1000; end
      OP_ADDI:    begin opc_s = 6'h08; fmt_s = FMT_I; use_s = 4'b1100; end
      OP_ADDIU:   begin opc_s = 6'h09; fmt_s = FMT_I; use_s = 4'b1100; end
      OP_SLTI:    begin opc_s = 6'h0A; fmt_s = FMT_I; use_s = 4'b1100; end
      OP_SLTIU:   begin opc_s = 6'h0B; fmt_s = FMT_I; use_s = 4'b1100; end
      OP_ANDI:    begin opc_s = 6'h0C; fmt_s = FMT_I; use_s = 4'b1100; end
      OP_ORI:     begin opc_s = 6'h0D; fmt_s = FMT_I; use_s = 4'b1100; end
      OP_XORI:    begin opc_s = 6'h0E; fmt_s = FMT_I; use_s = 4'b1100; end
      OP_LUI:     begin opc_s = 6'h0F; fmt_s = FMT_I; use_s = 4'b0100; end
      // CP0 moves carry the select in func[2:0]; bits [10:3] stay zero
      OP_MFC0:    begin opc_s = 6'h10; use_s = 4'b0110; fn_s = {3'b000, req_sel}; end
      OP_MTC0:    begin opc_s = 6'h10; use_s = 4'b0110; fn_s = {3'b000, req_sel}; fix_rs_s = 5'b00100; end
      OP_TLBR:    begin opc_s = 6'h10; fix_rs_s = 5'b10000; fn_s = 6'h01; end
      OP_TLBWI:   begin opc_s = 6'h10; fix_rs_s = 5'b10000; fn_s = 6'h02; end
      OP_TLBWR:   begin opc_s = 6'h10; fix_rs_s = 5'b10000; fn_s = 6'h06; end
      OP_TLBP:    begin opc_s = 6'h10; fix_rs_s = 5'b10000; fn_s = 6'h08; end
      OP_ERET:    begin opc_s = 6'h10; fix_rs_s = 5'b10000; fn_s = 6'h18; end
      OP_MADD:    begin opc_s = 6'h1C; fn_s = 6'h00; use_s = 4'b1100; end
      OP_MADDU:   begin opc_s = 6'h1C; fn_s = 6'h01; use_s = 4'b1100; end
      OP_MUL:     begin opc_s = 6'h1C; fn_s = 6'h02; use_s = 4'b1110; end
      OP_MSUB:    begin opc_s = 6'h1C; fn_s = 6'h04; use_s = 4'b1100; end
      OP_MSUBU:   begin opc_s = 6'h1C; fn_s = 6'h05; use_s = 4'b1100; end
      OP_CLZ:     begin opc_s = 6'h1C; fn_s = 6'h20; use_s = 4'b1110; end
      OP_CLO:     begin opc_s = 6'h1C; fn_s = 6'h21; use_s = 4'b1110; end
      OP_LB:      begin opc_s = 6'h20; fmt_s = FMT_I; use_s = 4'b1100; end
      OP_LH:      begin opc_s = 6'h21; fmt_s = FMT_I; use_s = 4'b1100; end
      OP_LWL:     begin opc_s = 6'h22; fmt_s = FMT_I; use_s = 4'b1100; end
      OP_LW:      begin opc_s = 6'h23; fmt_s = FMT_I; use_s = 4'b1100; end
      OP_LBU:     begin opc_s = 6'h24; fmt_s = FMT_I; use_s = 4'b1100; end
      OP_LHU:     begin opc_s = 6'h25; fmt_s = FMT_I; use_s = 4'b1100; end
      OP_LWR:     begin opc_s = 6'h26; fmt_s = FMT_I; use_s = 4'b1100; end
      OP_SB:      begin opc_s = 6'h28; fmt_s = FMT_I; use_s = 4'b1100; end
      OP_SH:      begin opc_s = 6'h29; fmt_s = FMT_I; use_s = 4'b1100; end
      OP_SWL:     begin opc_s = 6'h2A; fmt_s = FMT_I; use_s = 4'b1100; end
      OP_SW:      begin opc_s = 6'h2B; fmt_s = FMT_I; use_s = 4'b1100; end
      OP_SWR:     begin opc_s = 6'h2E; fmt_s = FMT_I; use_s = 4'b1100; end
      OP_CACHE:   begin opc_s = 6'h2F; fmt_s = FMT_I; use_s = 4'b1100; end
      default:    legal_s = 1'b0;
    endcase
  end

  assign rs_s = (use_s[3] ? req_rs : 5'd0) | fix_rs_s;
  assign rt_s = (use_s[2] ? req_rt : 5'd0) | fix_rt_s;
  assign rd_s = use_s[1] ? req_rd : 5'd0;
  assign sa_s = use_s[0] ? req_sa : 5'd0;

  // Assemble the word in the layout of the selected format
  always_comb begin
    word_s = 32'd0;
    case (fmt_s)
      FMT_R:   word_s = {opc_s, rs_s, rt_s, rd_s, sa_s, fn_s};
      FMT_I:   word_s = {opc_s, rs_s, rt_s, req_imm};
      FMT_J:   word_s = {opc_s, req_jidx};
      FMT_C:   word_s = {6'h00, req_jidx[25:6], fn_s};
      default: word_s = 32'd0;
    endcase
  end

  assign req_ready = (count_r < FULL_C) & ~flush;
  assign push_s    = req_valid & req_ready & legal_s;
  assign illegal_s = req_valid & req_ready & ~legal_s;
  assign pop_s     = out_valid_r & out_ready;

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= 32'd0;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      out_valid_r <= 1'b0;
    end else if (flush) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      out_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= word_s;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10: begin
          count_r     <= count_r + (AW+1)'(1);
          out_valid_r <= 1'b1;
        end
        2'b01: begin
          count_r     <= count_r - (AW+1)'(1);
          out_valid_r <= (count_r != (AW+1)'(1));
        end
        default: count_r <= count_r;
      endcase
    end
  end

  // Saturating counters and the sticky first-illegal record; flush leaves them alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      emit_cnt_r    <= '0;
      illegal_cnt_r <= '0;
      err_r         <= 1'b0;
      err_op_r      <= OP_INVALID;
    end else begin
      if (push_s && (emit_cnt_r != {CNT_W{1'b1}})) emit_cnt_r <= emit_cnt_r + CNT_W'(1);
      if (illegal_s) begin
        if (illegal_cnt_r != {CNT_W{1'b1}}) illegal_cnt_r <= illegal_cnt_r + CNT_W'(1);
        if (!err_r) err_op_r <= req_op;
        err_r <= 1'b1;
      end
    end
  end

  assign out_valid   = out_valid_r;
  assign out_inst    = mem_r[rd_ptr_r];
  assign err         = err_r;
  assign err_op      = err_op_r;
  assign emit_cnt    = emit_cnt_r;
  assign illegal_cnt = illegal_cnt_r;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: expected words are queued on acceptance and
// compared against the FIFO head at each output handshake.
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  operation_t  req_op = OP_INVALID;
  logic [4:0]  req_rs = 5'd0, req_rt = 5'd0, req_rd = 5'd0, req_sa = 5'd0;
  logic [15:0] req_imm = 16'd0;
  logic [25:0] req_jidx = 26'd0;
  logic [2:0]  req_sel = 3'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic        err;
  operation_t  err_op;
  logic [15:0] emit_cnt, illegal_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;
  int exp_emit = 0;
  int exp_ill = 0;
  logic [31:0] sb[$];

  inst_encoder #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_sa(req_sa),
    .req_imm(req_imm), .req_jidx(req_jidx), .req_sel(req_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .err(err), .err_op(err_op), .emit_cnt(emit_cnt), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] addiu_w(input int i);
    return 32'h24000000 | (32'(i) << 21) | (32'(i) << 16) | 32'(i);
  endfunction

  task automatic set_req(input operation_t op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sa, input logic [15:0] imm,
                         input logic [25:0] jidx, input logic [2:0] sel);
    req_op = op; req_rs = rs; req_rt = rt; req_rd = rd; req_sa = sa;
    req_imm = imm; req_jidx = jidx; req_sel = sel;
  endtask

  // Called at posedge+1; returns at posedge+1 after the request has been accepted
  task automatic send(input operation_t op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sa, input logic [15:0] imm,
                      input logic [25:0] jidx, input logic [2:0] sel,
                      input logic has_exp, input logic [31:0] exp);
    logic ok;
    set_req(op, rs, rt, rd, sa, imm, jidx, sel);
    req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
    end
    if (ok) begin
      @(posedge clk);
      if (has_exp) begin
        sb.push_back(exp);
        exp_emit++;
      end else begin
        exp_ill++;
      end
      #1 req_valid = 1'b0;
    end else begin
      check("accept_timeout", 32'(ok), 32'd1);
      req_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_op", {25'd0, err_op}, {25'd0, OP_INVALID});
    check("rst_emit_cnt", 32'(emit_cnt), 32'd0);
    check("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
  endtask

  // Scoreboard: each output handshake must deliver the oldest expected word
  always @(negedge clk) begin
    if (rst_n && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_word", 32'(sb.size()), 32'd1);
      end else begin
        check("out_inst", out_inst, sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 check_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic R-type with one-cycle latency
    out_ready = 1'b1;
    send(OP_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 3'd0, 1'b1, 32'h00221821);
    @(negedge clk);
    check("addu_latency_valid", 32'(out_valid), 32'd1);
    check("addu_emit_cnt", 32'(emit_cnt), 32'd1);
    @(posedge clk); #1;

    // Back-to-back LUI and J
    send(OP_LUI, 5'd7, 5'd4, 5'd0, 5'd0, 16'h1234, 26'd0, 3'd0, 1'b1, 32'h3C041234);
    send(OP_J, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h0100000, 3'd0, 1'b1, 32'h08100000);
    send(OP_MFC0, 5'd9, 5'd8, 5'd12, 5'd3, 16'd0, 26'd0, 3'd0, 1'b1, 32'h40086000);
    send(OP_ERET, 5'd1, 5'd2, 5'd3, 5'd4, 16'hFFFF, 26'h3FFFFFF, 3'd7, 1'b1, 32'h42000018);
    send(OP_BGEZAL, 5'd5, 5'd3, 5'd0, 5'd0, 16'hFFFF, 26'd0, 3'd0, 1'b1, 32'h04B1FFFF);
    // Unused fields are forced to zero
    send(OP_SLL, 5'd7, 5'd2, 5'd3, 5'd4, 16'd0, 26'd0, 3'd0, 1'b1, 32'h00021900);
    send(OP_JR, 5'd31, 5'd5, 5'd6, 5'd0, 16'd0, 26'd0, 3'd0, 1'b1, 32'h03E00008);
    send(OP_MULT, 5'd4, 5'd5, 5'd6, 5'd7, 16'd0, 26'd0, 3'd0, 1'b1, 32'h00850018);
    send(OP_SYSCALL, 5'd3, 5'd3, 5'd3, 5'd3, 16'd0, 26'h000007F, 3'd0, 1'b1, 32'h0000004C);
    send(OP_SW, 5'd29, 5'd31, 5'd0, 5'd0, 16'h0010, 26'd0, 3'd0, 1'b1, 32'hAFBF0010);
    send(OP_BLEZ, 5'd3, 5'd9, 5'd0, 5'd0, 16'h0004, 26'd0, 3'd0, 1'b1, 32'h18600004);
    send(OP_MTC0, 5'd0, 5'd9, 5'd12, 5'd0, 16'd0, 26'd0, 3'd1, 1'b1, 32'h40896001);
    send(OP_MUL, 5'd1, 5'd2, 5'd3, 5'd5, 16'd0, 26'd0, 3'd0, 1'b1, 32'h70221802);
    repeat (3) @(posedge clk);
    #1;

    // Fill to DEPTH, then a pop while full must not make room
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++)
      send(OP_ADDIU, 5'(i), 5'(i), 5'd0, 5'd0, 16'(i), 26'd0, 3'd0, 1'b1, addiu_w(i));
    set_req(OP_ADDIU, 5'd5, 5'd5, 5'd0, 5'd0, 16'd5, 26'd0, 3'd0);
    req_valid = 1'b1;
    @(negedge clk);
    check("full_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("full_pop_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("full_no_push", 32'(emit_cnt), 32'(exp_emit));
    @(negedge clk);
    check("room_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    sb.push_back(addiu_w(5));
    exp_emit++;
    #1 req_valid = 1'b0;
    check("push_after_room", 32'(emit_cnt), 32'(exp_emit));
    repeat (8) @(posedge clk);
    #1;

    // Illegal op dropped, legal op after it still emitted
    send(OP_INVALID, 5'd1, 5'd1, 5'd1, 5'd1, 16'd1, 26'd1, 3'd1, 1'b0, 32'd0);
    send(OP_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 3'd0, 1'b1, 32'h00221821);
    @(negedge clk);
    check("ill_cnt1", 32'(illegal_cnt), 32'd1);
    check("ill_err", 32'(err), 32'd1);
    check("ill_err_op", {25'd0, err_op}, {25'd0, OP_INVALID});
    @(posedge clk); #1;
    send(OP_BEQL, 5'd1, 5'd2, 5'd0, 5'd0, 16'd8, 26'd0, 3'd0, 1'b0, 32'd0);
    @(negedge clk);
    check("ill_cnt2", 32'(illegal_cnt), 32'd2);
    check("ill_err_op_kept", {25'd0, err_op}, {25'd0, OP_INVALID});
    check("ill_emit_cnt", 32'(emit_cnt), 32'(exp_emit));
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;

    // Flush with 3 entries queued and a request presented
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++)
      send(OP_ADDIU, 5'(i), 5'(i), 5'd0, 5'd0, 16'(i), 26'd0, 3'd0, 1'b1, addiu_w(i));
    set_req(OP_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 3'd0);
    req_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    req_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_emit_cnt", 32'(emit_cnt), 32'(exp_emit));
    check("flush_err_kept", 32'(err), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(OP_ORI, 5'd2, 5'd3, 5'd0, 5'd0, 16'hBEEF, 26'd0, 3'd0, 1'b1, 32'h3443BEEF);
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a stream
    out_ready = 1'b0;
    send(OP_ADDIU, 5'd6, 5'd6, 5'd0, 5'd0, 16'd6, 26'd0, 3'd0, 1'b1, addiu_w(6));
    send(OP_ADDIU, 5'd7, 5'd7, 5'd0, 5'd0, 16'd7, 26'd0, 3'd0, 1'b1, addiu_w(7));
    rst_n = 1'b0;
    #2 check_reset();
    sb.delete();
    exp_emit = 0;
    exp_ill = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("post_rst_no_word", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // err_op captures only the first illegal op after reset
    send(OP_BLTZALL, 5'd1, 5'd0, 5'd0, 5'd0, 16'd4, 26'd0, 3'd0, 1'b0, 32'd0);
    send(OP_BEQL, 5'd1, 5'd2, 5'd0, 5'd0, 16'd4, 26'd0, 3'd0, 1'b0, 32'd0);
    @(negedge clk);
    check("first_err_op", {25'd0, err_op}, {25'd0, OP_BLTZALL});
    check("ill_cnt_after_rst", 32'(illegal_cnt), 32'(exp_ill));
    check("emit_after_rst", 32'(emit_cnt), 32'd0);
    @(posedge clk); #1;

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Builds 32-bit MIPS32 instruction words from an operation_t code plus operand fields. It performs the inverse mapping of the decode stage's inst→operation mapping.
- Used by the self-test instruction injector and the trap/refill stub generator to feed the fetch path.
- Requests arrive over a valid/ready handshake. Encoded words are buffered in an internal FIFO and drained over a second valid/ready handshake.
- Unencodable operations are dropped, counted and reported.

Parameters:
- DEPTH, 4, output FIFO entries (power of two, ≥2)
- CNT_W, 16, width of emitted and illegal counters

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of FIFO contents and pending state
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_op  in  $bits(operation_t)  operation to encode
- req_rs/req_rt/req_rd/req_sa  in  5 each  register and shift fields
- req_imm  in  16  immediate or offset
- req_jidx  in  26  jump index; [25:6] also supplies the SYSCALL/BREAK code
- req_sel  in  3  CP0 select
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes head when out_valid & out_ready
- out_inst  out  32  encoded word at FIFO head
- err  out  1  sticky; set on first illegal request
- err_op  out  $bits(operation_t)  op of first illegal request
- emit_cnt  out  CNT_W  words pushed into the FIFO
- illegal_cnt  out  CNT_W  requests dropped as illegal

Behaviour:
- Reset values:
  - FIFO empty.
  - out_valid=0, out_inst=0, err=0, err_op=OP_INVALID.
  - Both counters 0.
  - req_ready=1.
- Ready rule: req_ready = (occupancy < DEPTH) & ~flush. A pop in the same cycle does not make room for a push when the FIFO is full.
- Encoding is combinational on the request fields. The word is written into the FIFO on acceptance. Latency: the word is visible on out_inst 1 cycle after acceptance if the FIFO was empty.
- Field placement:
  - SPECIAL: op=0, rs, rt, rd, sa, func.
  - SYSCALL/BREAK: op=0, code=req_jidx[25:6] in [25:6], func.
  - REGIMM: op=000001, rs, rt=sub-code, imm.
  - I-type, load, store, branch, CACHE: op, rs, rt, imm.
  - BLEZ/BGTZ: rt=0.
  - LUI: rs=0.
  - J/JAL: op, jidx.
  - MFC0/MTC0: op=010000, rs=00000 or 00100, rt, rd, [10:3]=0, sel.
  - TLBR/TLBWI/TLBWR/TLBP/ERET: op=010000, bit25=1, [24:6]=0, func.
  - SPECIAL2: op=011100, rs, rt, rd, sa=0, func.
- Opcode and func values are exactly those the decoder maps to each operation_t. Encode then decode must round-trip to the same operation.
- Fields an instruction does not use are forced to zero, whatever the request supplied. Examples: SLL rs=0; JR rt=rd=0; MULT rd=sa=0.
- Illegal ops are OP_INVALID and any operation with no decoder mapping (branch-likely forms, BLTZALL/BGEZALL). For these:
  - The request is accepted (ready consumed) but nothing is pushed.
  - illegal_cnt increments.
  - err is set. err_op is captured only if err was previously 0.
- Simultaneous push and pop with 0 < occupancy < DEPTH: occupancy is unchanged and ordering is preserved.
- Pointers wrap modulo DEPTH.
- Counters saturate at all-ones.
- flush: in the same cycle, occupancy goes to 0, any push is ignored, and out_valid=0 from the next cycle. err and the counters are preserved. Only rst_n clears them.
- rst_n asserted mid-stream: all state clears immediately and asynchronously. No partial word is emitted after deassertion.
- out_inst holds a stable value while out_valid=1 and out_ready=0.

Test Plan:
- ADDU rs=1 rt=2 rd=3, out_ready=1 → out_inst=0x00221821 one cycle later, emit_cnt=1.
- LUI rt=4 imm=0x1234, then J jidx=0x0100000, back-to-back → 0x3C041234 then 0x08100000, in order.
- MFC0 rt=8 rd=12 sel=0 → 0x40086000. ERET → 0x42000018. BGEZAL rs=5 imm=0xFFFF → 0x04B1FFFF.
- out_ready=0, push DEPTH+1 requests → req_ready drops after the 4th. Then a simultaneous pop and req_valid with the FIFO full → no push that cycle, push on the next cycle. Drain → FIFO order intact.
- OP_INVALID, then a legal op → no word from the first, illegal_cnt=1, err=1, err_op=OP_INVALID. A second illegal op does not change err_op.
- Fill 3 entries, assert flush → out_valid=0 next cycle, emit_cnt unchanged. rst_n pulse mid-stream → all outputs at reset values.
